// File: rtl/regfile_wport_arbiter.sv
// Shares the register file write port between writeback (req0) and the
// multi-cycle unit (req1): fixed priority to req0 with a starvation force-grant for req1.
module regfile_wport_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        req0_valid,
    input  logic [4:0]  req0_rd,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_rd,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] rf_wsel,
    output logic        starved
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        force_grant;

    assign force_grant = (wait_cnt_q == LIMIT);
    assign starved     = force_grant && req1_valid;

    // Ready is a pure function of valids, hold and wait_cnt, so there is no ready->valid loop.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!hold) begin
            if (force_grant && req1_valid) begin
                req1_ready = 1'b1;
            end else if (req0_valid) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1_valid || req1_ready) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // A write to x0 still loads address/data but never raises the enable.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (req1_valid && req1_ready) begin
            rf_we_d    = (req1_rd != 5'd0);
            rf_waddr_d = req1_rd;
            rf_wdata_d = req1_data;
        end else if (req0_valid && req0_ready) begin
            rf_we_d    = (req0_rd != 5'd0);
            rf_waddr_d = req0_rd;
            rf_wdata_d = req0_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_wsel  = rf_we_q ? (32'd1 << rf_waddr_q) : 32'd0;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed + randomized bench for regfile_wport_arbiter against a cycle-level
// behavioural model of the grant rules and the registered write port.
module tb_regfile_wport_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst, hold;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we, starved;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rf_wsel;

    regfile_wport_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wsel(rf_wsel),
        .starved(starved)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Model: how many consecutive cycles req1 has been kept waiting, plus the last write.
    int          denied;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          exp_r0, exp_r1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        denied = 0;
        m_we   = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".rf_we"},    {31'd0, rf_we}, {31'd0, m_we});
        chk({tag, ".rf_waddr"}, {27'd0, rf_waddr}, {27'd0, m_addr});
        chk({tag, ".rf_wdata"}, rf_wdata, m_data);
        chk({tag, ".rf_wsel"},  rf_wsel, m_we ? (32'd1 << m_addr) : 32'd0);
    endtask

    // One clock: check handshakes mid-cycle, advance the model on the edge, check registers after it.
    task automatic cycle(input string tag);
        bit at_limit;
        @(negedge clk);
        at_limit = (denied == LIMIT);
        exp_r1 = !hold && req1_valid && (at_limit || !req0_valid);
        exp_r0 = !hold && req0_valid && !(at_limit && req1_valid);
        chk({tag, ".req0_ready"}, {31'd0, req0_ready}, {31'd0, exp_r0});
        chk({tag, ".req1_ready"}, {31'd0, req1_ready}, {31'd0, exp_r1});
        chk({tag, ".starved"},    {31'd0, starved},    {31'd0, at_limit && req1_valid});
        @(posedge clk);
        if (exp_r1) begin
            m_we = (req1_rd != 0); m_addr = req1_rd; m_data = req1_data;
        end else if (exp_r0) begin
            m_we = (req0_rd != 0); m_addr = req0_rd; m_data = req0_data;
        end else begin
            m_we = 1'b0;
        end
        if (!req1_valid || exp_r1) denied = 0;
        else if (denied < LIMIT) denied++;
        #1;
        chk_outputs(tag);
    endtask

    initial begin
        model_reset();
        rst = 1'b0; hold = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hA5A5_0005;
        req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h5A5A_0007;

        // Reset with both requesters valid
        #3;
        chk_outputs("reset");
        chk("reset.starved",    {31'd0, starved},    32'd0);
        chk("reset.req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("reset.req1_ready", {31'd0, req1_ready}, 32'd0);
        #5 rst = 1'b1;
        cycle("first");
        chk("first.rf_wsel", rf_wsel, 32'h0000_0020);

        // Both valid continuously: req0 x4, then a forced req1, repeating
        for (int i = 0; i < 10; i++) cycle("starve");

        // req1 alone
        req0_valid = 1'b0; req1_rd = 5'd31; req1_data = 32'hDEAD_BEEF;
        cycle("req1_alone");
        chk("req1_alone.wsel", rf_wsel, 32'h8000_0000);
        chk("req1_alone.data", rf_wdata, 32'hDEAD_BEEF);

        // Write to x0 is accepted but not enabled
        req1_valid = 1'b0; req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'h1234_5678;
        cycle("x0");
        chk("x0.we",   {31'd0, rf_we}, 32'd0);
        chk("x0.wsel", rf_wsel, 32'd0);
        chk("x0.data", rf_wdata, 32'h1234_5678);

        // Hold with req1 waiting, then release with req0 also valid
        hold = 1'b1; req0_valid = 1'b0; req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h0000_0909;
        for (int i = 0; i < 6; i++) cycle("hold");
        chk("hold.starved", {31'd0, starved}, 32'd1);
        hold = 1'b0; req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h0000_0303;
        cycle("release");
        chk("release.waddr", {27'd0, rf_waddr}, 32'd9);
        req1_valid = 1'b0;
        cycle("after_release");
        chk("after_release.waddr", {27'd0, rf_waddr}, 32'd3);

        // Reset asserted in the cycle after a req0 transfer
        req0_rd = 5'd12; req0_data = 32'hCAFE_0012;
        cycle("pre_reset");
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("midreset.we",   {31'd0, rf_we}, 32'd0);
        chk("midreset.wsel", rf_wsel, 32'd0);
        @(posedge clk);
        #1;
        chk_outputs("midreset_hold");
        #2 rst = 1'b1;
        cycle("re_present");

        // Randomized traffic; requesters keep their request stable until accepted
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || exp_r0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_rd    = 5'($urandom_range(0, 31));
                req0_data  = $urandom;
            end
            if (!req1_valid || exp_r1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_rd    = 5'($urandom_range(0, 31));
                req1_data  = $urandom;
            end
            hold = ($urandom_range(0, 7) == 0);
            cycle("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
